// File: rtl/prio_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : prio_arbiter_4
// Brief    : Four-requester arbiter that grants to the highest index, holds the
//            grant until release or MAX_HOLD expiry, and then idles one cycle.
//            Define ARB_ROUND_ROBIN_EN for rotating priority.
// Revision : 1.0 - initial release
// ============================================================================
module prio_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       expired
);

    localparam bit         c_hold_en   = (MAX_HOLD != 0);
    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic       r_gnt_valid;
    logic       r_expired;

    logic [1:0] w_win_id;
    logic       w_win_any;
    logic       w_owner_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] r_last;
    logic [1:0] w_idx;

    // Walk from lowest to highest priority so the highest-priority hit lands last.
    always_comb begin
        w_win_id = 2'b00;
        w_idx    = 2'b00;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_last - 2'd1 - 2'(k);
            if (req[w_idx]) begin
                w_win_id = w_idx;
            end
        end
    end
`else
    always_comb begin
        w_win_id = 2'd0;
        if (req[3])      w_win_id = 2'd3;
        else if (req[2]) w_win_id = 2'd2;
        else if (req[1]) w_win_id = 2'd1;
    end
`endif

    assign w_win_any   = |req;
    assign w_owner_req = req[r_gnt_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'b00;
            r_gnt_valid <= 1'b0;
            r_expired   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last      <= 2'b00;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_expired <= 1'b0;
                    r_cnt     <= 8'd0;
                    if (w_win_any) begin
                        r_state     <= ST_GRANT;
                        r_gnt       <= 4'b0001 << w_win_id;
                        r_gnt_id    <= w_win_id;
                        r_gnt_valid <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last      <= w_win_id;
`endif
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req) begin
                        r_state     <= ST_IDLE;
                        r_gnt       <= 4'b0000;
                        r_gnt_id    <= 2'b00;
                        r_gnt_valid <= 1'b0;
                        r_expired   <= 1'b0;
                    end else if (c_hold_en && (r_cnt == c_hold_last)) begin
                        r_state     <= ST_IDLE;
                        r_gnt       <= 4'b0000;
                        r_gnt_id    <= 2'b00;
                        r_gnt_valid <= 1'b0;
                        r_expired   <= 1'b1;
                    end else begin
                        // Saturate so an unlimited grant never wraps the counter.
                        if (r_cnt != 8'hFF) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                        r_expired <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign expired   = r_expired;

endmodule
`default_nettype wire
